// File: rtl/wb_commit_unit.sv
// wb_commit_unit: write-back / commit stage of an in-order pipeline.
//
// Latches one instruction from the memory stage. It commits the register-file
// write, the TLB write/fill, or the TLB search/read request. Exceptions, ertn
// and refetch raise a pipeline flush. The unit also counts retired instructions.
//
// Ports
//   clk, reset                 clock (rising edge), asynchronous active-high reset
//   ms_to_ws_valid, ws_allowin upstream valid/allowin handshake
//   in_pc, in_result, in_dest, in_gr_we        instruction payload
//   in_ex, in_ertn, in_refetch                 exception / ertn / refetch flags
//   in_tlb_op, in_tlb_widx                     TLB op (1 SRCH,2 RD,3 WR,4 FILL), WR index
//   rf_we, rf_waddr, rf_wdata                  register-file write port
//   flush_pipe, flush_kind, refetch_pc         flush request (01 ex, 10 ertn, 11 refetch)
//   tlb_rd_req, tlb_we, tlb_windex             TLB control
//   instret                                    committed-instruction count
//   debug_wb_*                                 trace/debug port
module wb_commit_unit #(
    parameter int unsigned PC_W        = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned RF_AW       = 5,
    parameter int unsigned TLB_IDX_W   = 4,
    parameter int unsigned FILL_MODE   = 0,
    parameter int unsigned FILL_STRIDE = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ms_to_ws_valid,
    output logic                 ws_allowin,
    input  logic [PC_W-1:0]      in_pc,
    input  logic [DATA_W-1:0]    in_result,
    input  logic [RF_AW-1:0]     in_dest,
    input  logic                 in_gr_we,
    input  logic                 in_ex,
    input  logic                 in_ertn,
    input  logic                 in_refetch,
    input  logic [2:0]           in_tlb_op,
    input  logic [TLB_IDX_W-1:0] in_tlb_widx,
    output logic                 rf_we,
    output logic [RF_AW-1:0]     rf_waddr,
    output logic [DATA_W-1:0]    rf_wdata,
    output logic                 flush_pipe,
    output logic [1:0]           flush_kind,
    output logic [PC_W-1:0]      refetch_pc,
    output logic                 tlb_rd_req,
    output logic                 tlb_we,
    output logic [TLB_IDX_W-1:0] tlb_windex,
    output logic [31:0]          instret,
    output logic [PC_W-1:0]      debug_wb_pc,
    output logic [3:0]           debug_wb_rf_wen,
    output logic [RF_AW-1:0]     debug_wb_rf_wnum,
    output logic [DATA_W-1:0]    debug_wb_rf_wdata
);

    localparam logic [2:0] OP_SRCH = 3'd1;
    localparam logic [2:0] OP_RD   = 3'd2;
    localparam logic [2:0] OP_WR   = 3'd3;
    localparam logic [2:0] OP_FILL = 3'd4;

    localparam logic [TLB_IDX_W-1:0] FILL_STEP =
        (FILL_MODE != 0) ? TLB_IDX_W'(FILL_STRIDE) : TLB_IDX_W'(1);

    typedef enum logic [0:0] {StIdle, StTlbWait} state_t;

    state_t                 state_q, state_d;
    logic                   ws_valid_q;
    logic [PC_W-1:0]        pc_q;
    logic [DATA_W-1:0]      result_q;
    logic [RF_AW-1:0]       dest_q;
    logic                   gr_we_q, ex_q, ertn_q, refetch_q;
    logic [2:0]             op_q;
    logic [TLB_IDX_W-1:0]   widx_q;
    logic [TLB_IDX_W-1:0]   fill_idx_q;
    logic [31:0]            instret_q;

    logic excepting, is_tlb_read, tlb_start, ws_ready_go, commit;

    assign excepting   = ex_q || ertn_q || refetch_q;
    assign is_tlb_read = (op_q == OP_SRCH) || (op_q == OP_RD);

    // FSM next state and the stall it causes.
    always_comb begin
        state_d   = StIdle;
        tlb_start = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Excepting instructions never start a TLB lookup.
                if (ws_valid_q && is_tlb_read && !excepting) begin
                    tlb_start = 1'b1;
                    state_d   = StTlbWait;
                end
            end
            StTlbWait: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    assign ws_ready_go = !tlb_start;
    assign ws_allowin  = !ws_valid_q || ws_ready_go;
    assign tlb_rd_req  = tlb_start;

    // ertn still retires; ex and refetch do not.
    assign commit = ws_valid_q && ws_ready_go && !ex_q && !refetch_q;

    assign rf_we    = commit && gr_we_q;
    assign rf_waddr = dest_q;
    assign rf_wdata = result_q;

    assign flush_pipe = ws_valid_q && excepting;
    always_comb begin
        flush_kind = 2'b00;
        if (flush_pipe) begin
            if (ex_q)        flush_kind = 2'b01;
            else if (ertn_q) flush_kind = 2'b10;
            else             flush_kind = 2'b11;
        end
    end
    assign refetch_pc = pc_q;

    assign tlb_we = commit && ((op_q == OP_WR) || (op_q == OP_FILL));
    always_comb begin
        tlb_windex = '0;
        if (op_q == OP_WR)        tlb_windex = widx_q;
        else if (op_q == OP_FILL) tlb_windex = fill_idx_q;
    end

    assign instret           = instret_q;
    assign debug_wb_pc       = pc_q;
    assign debug_wb_rf_wen   = {4{rf_we}};
    assign debug_wb_rf_wnum  = dest_q;
    assign debug_wb_rf_wdata = result_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            ws_valid_q <= 1'b0;
            pc_q       <= '0;
            result_q   <= '0;
            dest_q     <= '0;
            gr_we_q    <= 1'b0;
            ex_q       <= 1'b0;
            ertn_q     <= 1'b0;
            refetch_q  <= 1'b0;
            op_q       <= '0;
            widx_q     <= '0;
            fill_idx_q <= '0;
            instret_q  <= '0;
        end else begin
            state_q <= state_d;
            // A flush kills both the current and the incoming instruction.
            if (flush_pipe) begin
                ws_valid_q <= 1'b0;
            end else if (ws_allowin) begin
                ws_valid_q <= ms_to_ws_valid;
            end
            if (ms_to_ws_valid && ws_allowin && !flush_pipe) begin
                pc_q      <= in_pc;
                result_q  <= in_result;
                dest_q    <= in_dest;
                gr_we_q   <= in_gr_we;
                ex_q      <= in_ex;
                ertn_q    <= in_ertn;
                refetch_q <= in_refetch;
                op_q      <= in_tlb_op;
                widx_q    <= in_tlb_widx;
            end
            if (commit) begin
                instret_q <= instret_q + 32'd1;
            end
            if (commit && (op_q == OP_FILL)) begin
                fill_idx_q <= fill_idx_q + FILL_STEP;
            end
        end
    end

endmodule
